// File: rtl/uart_framed_transmitter_pkg.sv
// Shared encodings and helpers for the uart_* blocks.
// The StBreak state exists only when UART_TX_BREAK_EN is defined.
package uart_framed_transmitter_pkg;

    localparam int unsigned UartParityNone = 0;
    localparam int unsigned UartParityOdd  = 1;
    localparam int unsigned UartParityEven = 2;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
`ifdef UART_TX_BREAK_EN
        , StBreak
`endif
    } tx_state_e;

    // Width of an occupancy counter that must represent 0..n inclusive.
    function automatic int unsigned count_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with occupancy count; pushes when full and pops when empty are dropped.
// Shared by the uart transmit path and intended for reuse by the receiver.
module uart_tx_fifo
    import uart_framed_transmitter_pkg::*;
#(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            push_i,
    input  logic [Width-1:0]                wdata_i,
    input  logic                            pop_i,
    output logic [Width-1:0]                rdata_o,
    output logic                            full_o,
    output logic                            empty_o,
    output logic [count_width(Depth)-1:0]   count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = count_width(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_framed_transmitter.sv
// Framed UART transmitter: FIFO-fed, configurable width/parity/stop bits, gapless frames.
// Define UART_TX_BREAK_EN to add the break_req input and the line-break state.
module uart_framed_transmitter
    import uart_framed_transmitter_pkg::*;
#(
    parameter int unsigned BAUD_RATE       = 9600,
    parameter int unsigned CLOCK_FREQUENCY = 100000000,
    parameter int unsigned DATA_BITS       = 8,
    parameter int unsigned PARITY          = 0,
    parameter int unsigned STOP_BITS       = 1,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic                                 clock,
    input  logic                                 reset,
`ifdef UART_TX_BREAK_EN
    input  logic                                 break_req,
`endif
    input  logic [DATA_BITS-1:0]                 data,
    input  logic                                 valid,
    output logic                                 ready,
    output logic                                 uart,
    output logic                                 busy,
    output logic [count_width(FIFO_DEPTH)-1:0]   fifo_count
);

    localparam int unsigned DIV   = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int unsigned BaudW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [BaudW-1:0] BaudLast = BaudW'(DIV - 1);
    localparam logic [3:0]       DataLast = 4'(DATA_BITS - 1);
    localparam logic [3:0]       StopLast = 4'(STOP_BITS - 1);

    if (DIV < 2) begin : g_bad_div
        $error("uart_framed_transmitter: CLOCK_FREQUENCY/BAUD_RATE must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_framed_transmitter: DATA_BITS must be 5..9");
    end
    if (PARITY > UartParityEven) begin : g_bad_parity
        $error("uart_framed_transmitter: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_framed_transmitter: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_framed_transmitter: FIFO_DEPTH must be a power of 2, >= 2");
    end

    tx_state_e              state_q;
    logic [BaudW-1:0]       baud_q;
    logic [3:0]             bit_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   par_q;
    logic                   uart_q;
`ifdef UART_TX_BREAK_EN
    logic                   mark_q;
`endif

    logic                   baud_end;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [DATA_BITS-1:0]   fifo_rdata;

    uart_tx_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (DATA_BITS)
    ) u_fifo (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (valid),
        .wdata_i (data),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign baud_end = (baud_q == BaudLast);
    assign ready    = !fifo_full;
    assign uart     = uart_q;
    assign busy     = (state_q != StIdle) || (fifo_count != '0);

    // A pop always coincides with the edge that starts the next start bit.
    always_comb begin
        pop = 1'b0;
        case (state_q)
            StIdle: begin
`ifdef UART_TX_BREAK_EN
                pop = !fifo_empty && !break_req;
`else
                pop = !fifo_empty;
`endif
            end
            StStop:  pop = !fifo_empty && baud_end && (bit_q == StopLast);
`ifdef UART_TX_BREAK_EN
            StBreak: pop = !fifo_empty && mark_q && baud_end;
`endif
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            uart_q  <= 1'b1;
`ifdef UART_TX_BREAK_EN
            mark_q  <= 1'b0;
`endif
        end else begin
            baud_q <= baud_end ? '0 : baud_q + BaudW'(1);
            case (state_q)
                StIdle: begin
                    baud_q <= '0;
`ifdef UART_TX_BREAK_EN
                    if (break_req) begin
                        state_q <= StBreak;
                        uart_q  <= 1'b0;
                        mark_q  <= 1'b0;
                    end
`endif
                end
                StStart: begin
                    if (baud_end) begin
                        state_q <= StData;
                        bit_q   <= '0;
                        uart_q  <= shift_q[0];
                        par_q   <= par_q ^ shift_q[0];
                        shift_q <= shift_q >> 1;
                    end
                end
                StData: begin
                    if (baud_end) begin
                        if (bit_q == DataLast) begin
                            bit_q <= '0;
                            if (PARITY != UartParityNone) begin
                                state_q <= StParity;
                                uart_q  <= (PARITY == UartParityOdd) ? ~par_q : par_q;
                            end else begin
                                state_q <= StStop;
                                uart_q  <= 1'b1;
                            end
                        end else begin
                            bit_q   <= bit_q + 4'd1;
                            uart_q  <= shift_q[0];
                            par_q   <= par_q ^ shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end
                end
                StParity: begin
                    if (baud_end) begin
                        state_q <= StStop;
                        bit_q   <= '0;
                        uart_q  <= 1'b1;
                    end
                end
                StStop: begin
                    if (baud_end) begin
                        if (bit_q == StopLast) state_q <= StIdle;
                        else                   bit_q   <= bit_q + 4'd1;
                    end
                end
`ifdef UART_TX_BREAK_EN
                StBreak: begin
                    // Hold space while requested, then one full bit period of mark.
                    if (!mark_q) begin
                        baud_q <= '0;
                        if (!break_req) begin
                            mark_q <= 1'b1;
                            uart_q <= 1'b1;
                        end
                    end else if (baud_end) begin
                        mark_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
`endif
                default: state_q <= StIdle;
            endcase

            if (pop) begin
                state_q <= StStart;
                uart_q  <= 1'b0;
                shift_q <= fifo_rdata;
                par_q   <= 1'b0;
                baud_q  <= '0;
                bit_q   <= '0;
            end
        end
    end

endmodule
